// File: rtl/dcpu_rf_pkg.sv
// dcpu_rf_pkg: shared register-file widths, index/word types and the zero-register index
package dcpu_rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);
  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;
  localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, outstanding-write counter and operand-ready generation
module rf_scoreboard #(
  parameter int NREG = dcpu_rf_pkg::NREG,
  parameter int AW = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_ready,
  output logic          rs2_ready,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          flush,
  output logic [AW:0]   pend_cnt,
  output logic          any_pend
);
  import dcpu_rf_pkg::*;
  logic [NREG-1:0] pend, pend_wr, pend_nxt;
  logic rsv_ok, rsv_set, wr_clr;
  logic [AW:0] cnt_nxt;
  assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == AW'(ZERO_IDX));
  assign pend_wr = pend & ~(NREG'(wr_en) << wr_addr);
  assign wr_clr = wr_en && pend[wr_addr];
  // a reservation counts as a new bit only if the slot is clear after the writeback clear
  assign rsv_set = rsv_ok && !pend_wr[rsv_addr];
  assign pend_nxt = (flush ? '0 : pend_wr) | (NREG'(rsv_ok) << rsv_addr);
  assign cnt_nxt = flush ? (AW+1)'(rsv_ok) : pend_cnt - (AW+1)'(wr_clr) + (AW+1)'(rsv_set);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= '0;
      pend_cnt <= '0;
    end else begin
      pend <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  assign any_pend = pend_cnt != '0;
  assign rs1_ready = !pend[rs1_addr] || (wr_en && wr_addr == rs1_addr);
  assign rs2_ready = !pend[rs2_addr] || (wr_en && wr_addr == rs2_addr);
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with write-through bypass and integrated write-pending scoreboard
module reg_file_sb #(
  parameter int XLEN = dcpu_rf_pkg::XLEN,
  parameter int NREG = dcpu_rf_pkg::NREG,
  parameter int AW = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush,
  output logic [AW:0]     pend_cnt,
  output logic            any_pend
);
  import dcpu_rf_pkg::*;
  logic [XLEN-1:0] regs [NREG];
  logic z1, z2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && !(ZERO_REG && wr_addr == AW'(ZERO_IDX))) begin
      regs[wr_addr] <= wr_data;
    end
  // reset also masks the bypass so nothing in flight leaks out while rst is low
  assign z1 = !rst || (ZERO_REG && rs1_addr == AW'(ZERO_IDX));
  assign z2 = !rst || (ZERO_REG && rs2_addr == AW'(ZERO_IDX));
  assign rs1_data = z1 ? '0 : (wr_en && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
  assign rs2_data = z2 ? '0 : (wr_en && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
  rf_scoreboard #(.NREG(NREG), .AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_ready(rs1_ready),
    .rs2_ready(rs2_ready),
    .rsv_en(rsv_en),
    .rsv_addr(rsv_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .flush(flush),
    .pend_cnt(pend_cnt),
    .any_pend(any_pend)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb with hand-computed expectations
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1_addr = '0, rs2_addr = '0, rsv_addr = '0, wr_addr = '0;
  logic [31:0] rs1_data, rs2_data, wr_data = '0;
  logic rs1_ready, rs2_ready, rsv_en = 1'b0, wr_en = 1'b0, flush = 1'b0, any_pend;
  logic [5:0] pend_cnt;
  int n_cmp = 0, n_bad = 0;
  reg_file_sb dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .pend_cnt(pend_cnt), .any_pend(any_pend)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    {wr_en, rsv_en, flush} = '0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
  endtask
  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
    tick();
  endtask
  initial begin
    #12;
    chk("rst_data1", rs1_data, 0);
    chk("rst_ready1", 32'(rs1_ready), 1);
    chk("rst_cnt", 32'(pend_cnt), 0);
    chk("rst_any", 32'(any_pend), 0);
    @(negedge clk) rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      chk($sformatf("init_d1_%0d", a), rs1_data, 0);
      chk($sformatf("init_r2_%0d", a), 32'(rs2_ready), 1);
    end
    wr(5, 32'hDEADBEEF);
    rs1_addr = 5; #1;
    chk("x5_read", rs1_data, 32'hDEADBEEF);
    chk("x5_cnt", 32'(pend_cnt), 0);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 0;
    rs1_addr = 0; #1;
    chk("x0_bypass_ignored", rs1_data, 0);
    tick();
    #1;
    chk("x0_data", rs1_data, 0);
    chk("x0_ready", 32'(rs1_ready), 1);
    chk("x0_cnt", 32'(pend_cnt), 0);
    rs2_addr = 7; rsv_en = 1'b1; rsv_addr = 7; #1;
    chk("rsv_same_cycle_ready", 32'(rs2_ready), 1);
    tick();
    chk("x7_pend_ready", 32'(rs2_ready), 0);
    chk("x7_pend_cnt", 32'(pend_cnt), 1);
    chk("x7_any", 32'(any_pend), 1);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; #1;
    chk("x7_bypass_data", rs2_data, 32'hA5A5A5A5);
    chk("x7_bypass_ready", 32'(rs2_ready), 1);
    tick();
    chk("x7_wb_cnt", 32'(pend_cnt), 0);
    chk("x7_wb_data", rs2_data, 32'hA5A5A5A5);
    chk("x7_wb_ready", 32'(rs2_ready), 1);
    rsv_en = 1'b1; rsv_addr = 3; wr(3, 32'h11);
    rs1_addr = 3; #1;
    chk("x3_data", rs1_data, 32'h11);
    chk("x3_ready", 32'(rs1_ready), 0);
    chk("x3_cnt", 32'(pend_cnt), 1);
    rsv_en = 1'b1; rsv_addr = 3; wr(3, 32'h33);
    chk("x3_rewr_cnt", 32'(pend_cnt), 1);
    wr(3, 32'h33);
    chk("x3_clear_cnt", 32'(pend_cnt), 0);
    wr(5'd1, 32'h100); wr(5'd2, 32'h200); wr(5'd4, 32'h400);
    rsv(5'd1); rsv(5'd2); rsv(5'd4);
    chk("three_pend_cnt", 32'(pend_cnt), 3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 9; tick();
    chk("flush_cnt", 32'(pend_cnt), 1);
    rs1_addr = 9; rs2_addr = 1; #1;
    chk("x9_ready", 32'(rs1_ready), 0);
    chk("x1_ready", 32'(rs2_ready), 1);
    chk("x1_data", rs2_data, 32'h100);
    rs1_addr = 2; rs2_addr = 4; #1;
    chk("x2_data", rs1_data, 32'h200);
    chk("x4_data", rs2_data, 32'h400);
    chk("x4_ready", 32'(rs2_ready), 1);
    rsv(5'd9);
    chk("rsv_repeat_cnt", 32'(pend_cnt), 1);
    flush = 1'b1; tick();
    chk("flush_only_cnt", 32'(pend_cnt), 0);
    rsv(5'd9); rsv(5'd10);
    chk("pre_rst_cnt", 32'(pend_cnt), 2);
    wr_en = 1'b1; wr_addr = 12; wr_data = 32'h77; rsv_en = 1'b1; rsv_addr = 11;
    rs1_addr = 12; rs2_addr = 9;
    #2 rst = 1'b0;
    #1;
    chk("async_cnt", 32'(pend_cnt), 0);
    chk("async_any", 32'(any_pend), 0);
    chk("async_d1", rs1_data, 0);
    chk("async_r2", 32'(rs2_ready), 1);
    @(posedge clk); #1;
    {wr_en, rsv_en} = '0;
    @(negedge clk) rst = 1'b1;
    #1;
    chk("post_x12", rs1_data, 0);
    chk("post_x9_ready", 32'(rs2_ready), 1);
    chk("post_cnt", 32'(pend_cnt), 0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); #1;
      chk($sformatf("post_d1_%0d", a), rs1_data, 0);
      chk($sformatf("post_r1_%0d", a), 32'(rs1_ready), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
